video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Generates raster timing for the HDMI/DVI output path: pixel counters, sync, data-enable and per-line/per-frame strobes. It drives the three tmds_encoder channels: vde, plus control data {vsync, hsync} on the blue channel and 2'b00 on red and green. It also issues pixel-fetch requests to the framebuffer reader LEAD cycles before the matching display timing, so fetch latency is hidden.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync asserted level (0 = active-low)
VSYNC_POL, 0, vsync asserted level (0 = active-low)
LEAD, 2, cycles from fetch request to display of that pixel (range 1..8)

Ports:
clk  in  1  pixel clock
rstn_i  in  1  asynchronous active-low reset
en_i  in  1  timing enable
req_o  out  1  fetch request for pixel (req_x_o, req_y_o)
req_x_o  out  $clog2(H_ACTIVE)  requested column (10 at default)
req_y_o  out  $clog2(V_ACTIVE)  requested row (9 at default)
hsync_o  out  1  horizontal sync, polarity per HSYNC_POL
vsync_o  out  1  vertical sync, polarity per VSYNC_POL
vde_o  out  1  video data enable, to encoder vde_i
cd_o  out  2  {vsync_o, hsync_o}, to blue-channel encoder cd_i
line_start_o  out  1  one-cycle pulse on first pixel of every line (h=0)
frame_start_o  out  1  one-cycle pulse at h=0, v=0

Behaviour:
- Reset is asynchronous on rstn_i low; clock is clk.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL is the vertical equivalent (525).
- Counter widths are $clog2(H_TOTAL) and $clog2(V_TOTAL).
- Line order: active [0, H_ACTIVE), front porch, sync, back porch. Frames use the same order.
- Counters h, v:
  - When en_i=1, h increments each cycle. At H_TOTAL-1, h wraps to 0 and v increments.
  - At V_TOTAL-1 with h at H_TOTAL-1, v wraps to 0.
  - When en_i=0, h and v are synchronously forced to 0, so re-enable always starts at the frame origin.
- Request stage: all registered, outputs valid one cycle after the counter value.
  - req_o = en_i & (h<H_ACTIVE) & (v<V_ACTIVE).
  - req_x_o = h and req_y_o = v when req_o=1, otherwise 0.
- Display stage: a LEAD-deep shift pipeline of {hs_raw, vs_raw, de, ls, fs}.
  - Input is decoded from the same counter value as the request stage.
  - hs_raw = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs_raw = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), whole-line granularity, changing at h=0.
  - de is the request condition; ls = en_i & (h==0); fs = ls & (v==0).
  - When en_i=0, an idle entry is inserted: all fields 0.
  - The pipeline keeps shifting while en_i=0, so it drains over LEAD cycles.
- Display outputs appear exactly LEAD cycles after the req_o of the same pixel.
  - hsync_o = hs_raw ^ ~HSYNC_POL; vsync_o = vs_raw ^ ~VSYNC_POL.
  - cd_o = {vsync_o, hsync_o}.
- Reset values: req_o=0, req_x_o=0, req_y_o=0, vde_o=0, line_start_o=0, frame_start_o=0.
  - Syncs reset to their deasserted level: hsync_o=vsync_o=~POL, i.e. 1 at default; cd_o=2'b11 at default.
  - Counters reset to 0 and the pipeline resets to idle entries.
- Reset or en_i drop mid-frame: no partial-line recovery; the next enabled cycle restarts at (0,0).
- Invariants: vde_o and a sync pulse are never asserted together, and no request is dropped or duplicated.

Decomposition:
- Package video_pkg holds:
  - a timing_t struct {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp, hpol, vpol};
  - localparam TIMING_640x480_60 with the defaults above;
  - an h_total/v_total helper function.
- One sub-module, video_delay_line: a parameterised-width, depth-LEAD shift register with asynchronous reset to a parameter RESET_VAL. It is reusable for aligning pixel data from the fetch path.

Test Plan:
- Reset held then released with en_i=1 -> all outputs at reset values during reset; first req_o at cycle 1 with (0,0); frame_start_o exactly LEAD cycles after that req_o.
- Free run, one line -> period 800 cycles; hsync_o low for 96 cycles with delayed h in [656,751]; vde_o high for 640 cycles per active line.
- Full frame -> 525 line_start_o pulses; vsync_o low for lines 490–491 (1600 cycles); exactly 307200 req_o and 307200 vde_o cycles; one frame_start_o.
- LEAD=4 build -> each vde_o rising edge is 4 cycles after the req_o edge; req_x_o sequence 0..639 with no gaps.
- en_i dropped at v=100, h=300 for 10 cycles -> req_o low next cycle; vde_o low after LEAD cycles; on re-enable req (0,0) and frame_start_o LEAD cycles later.
- rstn_i asserted mid-sync pulse -> hsync_o deasserts asynchronously (goes 1) without waiting for clk; counters restart at (0,0) after release.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and timing presets for the video output path.
package video_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
    logic        hpol;
    logic        vpol;
  } timing_t;

  localparam timing_t TIMING_640x480_60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
    hpol: 1'b0, vpol: 1'b0
  };

  // Sync fields are stored at their output level so the idle entry is the deasserted sync level.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic ls;
    logic fs;
  } disp_t;

  function automatic int h_total(timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int v_total(timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a chosen value.
module video_delay_line #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RESET_VAL;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel counters, fetch requests, and display
// timing delayed LEAD cycles behind the requests to hide fetch latency.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE  = int'(TIMING_640x480_60.h_active),
  parameter int H_FP      = int'(TIMING_640x480_60.h_fp),
  parameter int H_SYNC    = int'(TIMING_640x480_60.h_sync),
  parameter int H_BP      = int'(TIMING_640x480_60.h_bp),
  parameter int V_ACTIVE  = int'(TIMING_640x480_60.v_active),
  parameter int V_FP      = int'(TIMING_640x480_60.v_fp),
  parameter int V_SYNC    = int'(TIMING_640x480_60.v_sync),
  parameter int V_BP      = int'(TIMING_640x480_60.v_bp),
  parameter bit HSYNC_POL = TIMING_640x480_60.hpol,
  parameter bit VSYNC_POL = TIMING_640x480_60.vpol,
  parameter int LEAD      = 2
) (
  input  logic                          clk,
  input  logic                          rstn_i,
  input  logic                          en_i,
  output logic                          req_o,
  output logic [$clog2(H_ACTIVE)-1:0]   req_x_o,
  output logic [$clog2(V_ACTIVE)-1:0]   req_y_o,
  output logic                          hsync_o,
  output logic                          vsync_o,
  output logic                          vde_o,
  output logic [1:0]                    cd_o,
  output logic                          line_start_o,
  output logic                          frame_start_o
);

  localparam timing_t CFG = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP),
    hpol: HSYNC_POL, vpol: VSYNC_POL
  };
  localparam int H_TOTAL = h_total(CFG);
  localparam int V_TOTAL = v_total(CFG);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam disp_t IDLE = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, de: 1'b0, ls: 1'b0, fs: 1'b0};

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          active;
  disp_t         decode;
  disp_t         stage_q;
  disp_t         disp_q;

  // Dropping en_i parks the counters at the frame origin.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      h <= '0;
      v <= '0;
    end else if (!en_i) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  always_comb begin
    active = (h < H_ACT) && (v < V_ACT);
    decode = IDLE;
    if (en_i) begin
      decode.hsync = ((h >= HS_BEG) && (h < HS_END)) ^ ~HSYNC_POL;
      decode.vsync = ((v >= VS_BEG) && (v < VS_END)) ^ ~VSYNC_POL;
      decode.de    = active;
      decode.ls    = (h == '0);
      decode.fs    = (h == '0) && (v == '0);
    end
  end

  // Request outputs and the display entry are registered from the same counter value.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      req_o   <= 1'b0;
      req_x_o <= '0;
      req_y_o <= '0;
      stage_q <= IDLE;
    end else begin
      req_o   <= en_i && active;
      req_x_o <= (en_i && active) ? h[XW-1:0] : '0;
      req_y_o <= (en_i && active) ? v[YW-1:0] : '0;
      stage_q <= decode;
    end
  end

  video_delay_line #(
    .WIDTH     ($bits(disp_t)),
    .DEPTH     (LEAD),
    .RESET_VAL (IDLE)
  ) u_align (
    .clk    (clk),
    .rstn_i (rstn_i),
    .d      (stage_q),
    .q      (disp_q)
  );

  assign hsync_o       = disp_q.hsync;
  assign vsync_o       = disp_q.vsync;
  assign vde_o         = disp_q.de;
  assign line_start_o  = disp_q.ls;
  assign frame_start_o = disp_q.fs;
  assign cd_o          = {disp_q.vsync, disp_q.hsync};

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default 640x480 instance and a tiny-raster
// LEAD=4 instance, both checked every cycle against a pixel-count model.
module tb_video_timing_gen;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lead;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    bit req;
    int x;
    int y;
    bit hs;
    bit vs;
    bit de;
    bit ls;
    bit fs;
  } ent_t;

  logic clk;
  logic rstn_i;
  logic en_i;

  logic       req_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] rx_a;
  logic [8:0] ry_a;
  logic [1:0] cd_a;

  logic       req_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [3:0] rx_b;
  logic [2:0] ry_b;
  logic [1:0] cd_b;

  cfg_t cfg_a = '{ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33,
                  lead: 2, hpol: 1'b0, vpol: 1'b0};
  cfg_t cfg_b = '{ha: 12, hfp: 2, hsw: 3, hbp: 3, va: 5, vfp: 1, vsw: 2, vbp: 2,
                  lead: 4, hpol: 1'b1, vpol: 1'b0};

  int   cnt_a, cnt_b;
  ent_t hist_a[$];
  ent_t hist_b[$];
  int   vectors;
  int   miscompares;
  int   cycle;
  int   guard;

  video_timing_gen dut_a (
    .clk           (clk),
    .rstn_i        (rstn_i),
    .en_i          (en_i),
    .req_o         (req_a),
    .req_x_o       (rx_a),
    .req_y_o       (ry_a),
    .hsync_o       (hs_a),
    .vsync_o       (vs_a),
    .vde_o         (de_a),
    .cd_o          (cd_a),
    .line_start_o  (ls_a),
    .frame_start_o (fs_a)
  );

  video_timing_gen #(
    .H_ACTIVE (12), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (5),  .V_FP (1), .V_SYNC (2), .V_BP (2),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .LEAD (4)
  ) dut_b (
    .clk           (clk),
    .rstn_i        (rstn_i),
    .en_i          (en_i),
    .req_o         (req_b),
    .req_x_o       (rx_b),
    .req_y_o       (ry_b),
    .hsync_o       (hs_b),
    .vsync_o       (vs_b),
    .vde_o         (de_b),
    .cd_o          (cd_b),
    .line_start_o  (ls_b),
    .frame_start_o (fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The expected position is just the number of enabled cycles since the origin.
  function automatic ent_t entry(cfg_t c, bit en, int cnt);
    ent_t e;
    int htot, vtot, h, v;
    e = '{default: 0};
    if (!en) return e;
    htot  = c.ha + c.hfp + c.hsw + c.hbp;
    vtot  = c.va + c.vfp + c.vsw + c.vbp;
    h     = cnt % htot;
    v     = (cnt / htot) % vtot;
    e.req = (h < c.ha) && (v < c.va);
    e.x   = e.req ? h : 0;
    e.y   = e.req ? v : 0;
    e.hs  = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw);
    e.vs  = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw);
    e.de  = e.req;
    e.ls  = (h == 0);
    e.fs  = (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic modelReset();
    cnt_a = 0;
    cnt_b = 0;
    hist_a.delete();
    hist_b.delete();
    repeat (cfg_a.lead + 1) hist_a.push_back(entry(cfg_a, 1'b0, 0));
    repeat (cfg_b.lead + 1) hist_b.push_back(entry(cfg_b, 1'b0, 0));
  endtask

  task automatic modelEdge();
    if (!rstn_i) begin
      modelReset();
      return;
    end
    hist_a.push_back(entry(cfg_a, en_i, cnt_a));
    if (hist_a.size() > cfg_a.lead + 1) void'(hist_a.pop_front());
    hist_b.push_back(entry(cfg_b, en_i, cnt_b));
    if (hist_b.size() > cfg_b.lead + 1) void'(hist_b.pop_front());
    cnt_a = en_i ? cnt_a + 1 : 0;
    cnt_b = en_i ? cnt_b + 1 : 0;
  endtask

  task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s cycle=%0d: observed %0h, expected %0h", tag, cycle, observed, expected);
    end
  endtask

  task automatic checkInst(input string tag, input cfg_t c, input ent_t rq, input ent_t dp,
                           input logic req, input logic [31:0] x, input logic [31:0] y,
                           input logic hs, input logic vs, input logic de,
                           input logic [1:0] cd, input logic ls, input logic fs);
    bit exp_hs, exp_vs;
    exp_hs = dp.hs ? c.hpol : ~c.hpol;
    exp_vs = dp.vs ? c.vpol : ~c.vpol;
    checkField({tag, ".req_o"},         32'(req), 32'(rq.req));
    checkField({tag, ".req_x_o"},       x,        rq.x);
    checkField({tag, ".req_y_o"},       y,        rq.y);
    checkField({tag, ".hsync_o"},       32'(hs),  32'(exp_hs));
    checkField({tag, ".vsync_o"},       32'(vs),  32'(exp_vs));
    checkField({tag, ".vde_o"},         32'(de),  32'(dp.de));
    checkField({tag, ".cd_o"},          32'(cd),  32'({exp_vs, exp_hs}));
    checkField({tag, ".line_start_o"},  32'(ls),  32'(dp.ls));
    checkField({tag, ".frame_start_o"}, 32'(fs),  32'(dp.fs));
    checkField({tag, ".vde_vs_sync"},   32'(de && ((hs === c.hpol) || (vs === c.vpol))), 32'd0);
  endtask

  task automatic checkOutput();
    checkInst("a", cfg_a, hist_a[$], hist_a[0], req_a, 32'(rx_a), 32'(ry_a),
              hs_a, vs_a, de_a, cd_a, ls_a, fs_a);
    checkInst("b", cfg_b, hist_b[$], hist_b[0], req_b, 32'(rx_b), 32'(ry_b),
              hs_b, vs_b, de_b, cd_b, ls_b, fs_b);
  endtask

  task automatic applyStimulus(input bit en, input bit rst_n, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      en_i   = en;
      rstn_i = rst_n;
      @(posedge clk);
      cycle++;
      modelEdge();
      #1;
      checkOutput();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    rstn_i      = 1'b1;
    en_i        = 1'b0;
    modelReset();

    // Reset asserted before any clock edge must already show reset values.
    #2 rstn_i = 1'b0;
    #1 checkOutput();
    applyStimulus(1'b1, 1'b0, 4);

    // Free run: several lines of the 640x480 raster, many tiny frames.
    applyStimulus(1'b1, 1'b1, 2500);

    // Drop enable at tiny-raster (v=3, h=7) for 10 cycles.
    guard = 0;
    while ((cnt_b % 200) != 67 && guard < 400) begin
      applyStimulus(1'b1, 1'b1, 1);
      guard++;
    end
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b1, 1'b1, 300);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, int'($urandom_range(900, 30)));
      applyStimulus(1'b0, 1'b1, int'($urandom_range(12, 1)));
    end
    applyStimulus(1'b1, 1'b1, 1000);

    // Reset mid hsync pulse must deassert sync without a clock edge.
    guard = 0;
    while (hs_a !== 1'b0 && guard < 1000) begin
      applyStimulus(1'b1, 1'b1, 1);
      guard++;
    end
    if (guard >= 1000) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL hsync_wait: observed no hsync pulse in %0d cycles, expected one", guard);
    end
    applyStimulus(1'b1, 1'b1, 10);
    #2 rstn_i = 1'b0;
    #1;
    modelReset();
    checkOutput();
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b1, 1700);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
